// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word/register-index typedefs and the hazard sequencer state.
package cpu_types_pkg;
    localparam int WORD_BITS   = 32;
    localparam int REGIDX_BITS = 5;

    typedef logic [WORD_BITS-1:0]   word_t;
    typedef logic [REGIDX_BITS-1:0] regbits_t;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        REDIRECT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } hazard_state_t;

    // One bit per pipeline latch, IF/ID first.
    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } latch_ctl_t;
endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the hazard sequencer and the datapath latches / PC.
interface hazard_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
);
    logic              ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memread_EX;
    logic [REG_W-1:0]  rd_EX, rs_ID, rt_ID;
    logic              branch_taken_EX, jump_ID, halt_MEM;
    logic [ADDR_W-1:0] branch_target_EX;
    logic              pc_en, pc_redirect;
    logic [ADDR_W-1:0] redirect_addr;
    logic              ifid_en, ifid_flush, idex_en, idex_flush;
    logic              exmem_en, exmem_flush, memwb_en, memwb_flush;
    logic              halt;
    logic [CNT_W-1:0]  stall_count;

    modport hc (
        input  ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memread_EX, rd_EX, rs_ID, rt_ID,
               branch_taken_EX, branch_target_EX, jump_ID, halt_MEM,
        output pc_en, pc_redirect, redirect_addr, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush, halt, stall_count
    );

    modport tb (
        output ihit, dhit, dmemREN_MEM, dmemWEN_MEM, memread_EX, rd_EX, rs_ID, rt_ID,
               branch_taken_EX, branch_target_EX, jump_ID, halt_MEM,
        input  pc_en, pc_redirect, redirect_addr, ifid_en, ifid_flush, idex_en, idex_flush,
               exmem_en, exmem_flush, memwb_en, memwb_flush, halt, stall_count
    );
endinterface

// File: rtl/load_use_detect.sv
// Flags a decode instruction that reads the destination of a load still in EX.
module load_use_detect #(
    parameter int REG_W = 5
) (
    input  logic             i_memread,
    input  logic [REG_W-1:0] i_rd,
    input  logic [REG_W-1:0] i_rs,
    input  logic [REG_W-1:0] i_rt,
    output logic             o_loaduse
);
    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    assign o_loaduse = i_memread && (i_rd != '0) && ((i_rd == i_rs) || (i_rd == i_rt));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: Mealy latch and PC controls from a small state machine.
module pipeline_hazard_ctrl
    import cpu_types_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic      CLK,
    input  logic      RST,
    hazard_ctrl_if.hc bus
);
    hazard_state_t     r_state, w_next;
    logic [ADDR_W-1:0] r_target;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              r_halt;
    logic              w_dwait, w_loaduse, w_pc_en, w_latch_target;
    latch_ctl_t        w_en, w_fl;

    load_use_detect #(.REG_W(REG_W)) u_lud (
        .i_memread (bus.memread_EX),
        .i_rd      (bus.rd_EX),
        .i_rs      (bus.rs_ID),
        .i_rt      (bus.rt_ID),
        .o_loaduse (w_loaduse)
    );

    assign w_dwait = (bus.dmemREN_MEM | bus.dmemWEN_MEM) & ~bus.dhit;

    always_comb begin
        w_next         = r_state;
        w_en           = 4'b1111;
        w_fl           = 4'b0000;
        w_pc_en        = 1'b1;
        w_latch_target = 1'b0;
        if (r_state == HALTED || r_state == DRAIN) begin
            w_en    = 4'b0000;
            w_pc_en = 1'b0;
            if (r_state == DRAIN && !w_dwait) w_next = HALTED;
        end else if (w_dwait) begin
            w_en    = 4'b0000;
            w_pc_en = 1'b0;
        end else if (bus.halt_MEM) begin
            w_en    = 4'b0001;
            w_fl    = 4'b1110;
            w_pc_en = 1'b0;
            w_next  = DRAIN;
        end else if (r_state == REDIRECT) begin
            w_en    = 4'b0111;
            w_fl    = 4'b1000;
            w_pc_en = bus.ihit;
            if (bus.ihit) w_next = RUN;
        end else if (bus.branch_taken_EX) begin
            w_en    = 4'b0011;
            w_fl    = 4'b1100;
            w_pc_en = bus.ihit;
            if (!bus.ihit) begin
                w_next         = REDIRECT;
                w_latch_target = 1'b1;
            end
        end else if (w_loaduse) begin
            w_en    = 4'b0011;
            w_fl    = 4'b0100;
            w_pc_en = 1'b0;
        end else if (bus.jump_ID) begin
            w_en    = 4'b0111;
            w_fl    = 4'b1000;
            w_pc_en = bus.ihit;
        end else if (!bus.ihit) begin
            w_en    = 4'b0111;
            w_fl    = 4'b1000;
            w_pc_en = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= RUN;
            r_target    <= '0;
            r_stall_cnt <= '0;
            r_halt      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_latch_target) r_target <= bus.branch_target_EX;
            if (w_next == DRAIN) r_halt <= 1'b1;
            if ((r_state == RUN || r_state == REDIRECT) && !w_pc_en && r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // Redirect stays asserted throughout REDIRECT, even while a dwait holds the PC.
    assign bus.pc_redirect   = (r_state == REDIRECT) ||
                               (r_state == RUN && bus.branch_taken_EX && !w_dwait && !bus.halt_MEM);
    assign bus.redirect_addr = (r_state == REDIRECT) ? r_target : bus.branch_target_EX;
    assign bus.pc_en         = w_pc_en;
    assign bus.ifid_en       = w_en.ifid;
    assign bus.idex_en       = w_en.idex;
    assign bus.exmem_en      = w_en.exmem;
    assign bus.memwb_en      = w_en.memwb;
    assign bus.ifid_flush    = w_fl.ifid;
    assign bus.idex_flush    = w_fl.idex;
    assign bus.exmem_flush   = w_fl.exmem;
    assign bus.memwb_flush   = w_fl.memwb;
    assign bus.halt          = r_halt;
    assign bus.stall_count   = r_stall_cnt;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with a per-cycle reference model.
module tb_pipeline_hazard_ctrl;
    localparam int AW = 32;
    localparam int RW = 5;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;
    localparam int M_RUN = 0, M_REDIR = 1, M_DRAIN = 2, M_HALT = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int checks = 0;
    int failures = 0;

    int          m_mode = M_RUN;
    logic [AW-1:0] m_target = '0;
    int          m_cnt = 0;
    bit          m_halt = 1'b0;
    bit          cmp_on = 1'b0;

    hazard_ctrl_if #(.ADDR_W(AW), .REG_W(RW), .CNT_W(CW)) bus ();

    pipeline_hazard_ctrl #(.ADDR_W(AW), .REG_W(RW), .CNT_W(CW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit m_dwait();
        return (bus.dmemREN_MEM || bus.dmemWEN_MEM) && !bus.dhit;
    endfunction

    // Expected controls from the priority list; en/fl bits are {ifid, idex, exmem, memwb}.
    function automatic void model_ctl(output bit pc_en, output bit redir,
                                      output bit [3:0] en, output bit [3:0] fl);
        bit lu;
        lu = bus.memread_EX && bus.rd_EX != 0 && (bus.rd_EX == bus.rs_ID || bus.rd_EX == bus.rt_ID);
        redir = (m_mode == M_REDIR) ||
                (m_mode == M_RUN && bus.branch_taken_EX && !m_dwait() && !bus.halt_MEM);
        pc_en = 1; en = 4'b1111; fl = 4'b0000;
        if (m_mode == M_HALT || m_mode == M_DRAIN || m_dwait()) begin
            pc_en = 0; en = 4'b0000;
        end else if (bus.halt_MEM) begin
            pc_en = 0; en = 4'b0001; fl = 4'b1110;
        end else if (m_mode == M_REDIR) begin
            pc_en = bus.ihit; en = 4'b0111; fl = 4'b1000;
        end else if (bus.branch_taken_EX) begin
            pc_en = bus.ihit; en = 4'b0011; fl = 4'b1100;
        end else if (lu) begin
            pc_en = 0; en = 4'b0011; fl = 4'b0100;
        end else if (bus.jump_ID) begin
            pc_en = bus.ihit; en = 4'b0111; fl = 4'b1000;
        end else if (!bus.ihit) begin
            pc_en = 0; en = 4'b0111; fl = 4'b1000;
        end
    endfunction

    always @(posedge CLK) begin : model_upd
        bit pe, rd;
        bit [3:0] en, fl;
        if (RST) begin
            m_mode = M_RUN; m_target = '0; m_cnt = 0; m_halt = 0; cmp_on = 1;
        end else begin
            model_ctl(pe, rd, en, fl);
            if ((m_mode == M_RUN || m_mode == M_REDIR) && !pe && m_cnt < CNT_MAX) m_cnt++;
            if (m_mode == M_DRAIN) begin
                if (!m_dwait()) m_mode = M_HALT;
            end else if (m_mode != M_HALT && !m_dwait()) begin
                if (bus.halt_MEM) begin
                    m_mode = M_DRAIN; m_halt = 1;
                end else if (m_mode == M_REDIR) begin
                    if (bus.ihit) m_mode = M_RUN;
                end else if (bus.branch_taken_EX && !bus.ihit) begin
                    m_mode = M_REDIR; m_target = bus.branch_target_EX;
                end
            end
        end
    end

    always @(negedge CLK) begin : compare
        bit pe, rd;
        bit [3:0] en, fl;
        logic [3:0] a_en, a_fl;
        if (cmp_on) begin
            model_ctl(pe, rd, en, fl);
            a_en = {bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en};
            a_fl = {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush};
            chk("m_pc_en", bus.pc_en, pe);
            chk("m_pc_redirect", bus.pc_redirect, rd);
            chk("m_latch_en", a_en, en);
            chk("m_latch_flush", a_fl, fl);
            chk("m_halt", bus.halt, m_halt);
            chk("m_stall_count", bus.stall_count, m_cnt);
            chk("en_flush_excl", |(a_en & a_fl), 0);
            if (rd) chk("m_redirect_addr", bus.redirect_addr,
                        (m_mode == M_REDIR) ? m_target : bus.branch_target_EX);
        end
    end

    task automatic idle();
        bus.ihit = 1; bus.dhit = 0; bus.dmemREN_MEM = 0; bus.dmemWEN_MEM = 0;
        bus.memread_EX = 0; bus.rd_EX = 0; bus.rs_ID = 0; bus.rt_ID = 0;
        bus.branch_taken_EX = 0; bus.branch_target_EX = '0; bus.jump_ID = 0; bus.halt_MEM = 0;
    endtask

    task automatic nxt();
        @(posedge CLK); #1;
    endtask

    initial begin
        idle();
        RST = 1;
        repeat (2) @(posedge CLK);
        #1 RST = 0;
        @(negedge CLK);
        chk("rst_halt", bus.halt, 0);
        chk("rst_cnt", bus.stall_count, 0);
        chk("rst_pc_en", bus.pc_en, 1);
        chk("rst_en", {bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}, 4'hf);

        // load-use on rs
        nxt(); bus.memread_EX = 1; bus.rd_EX = 5; bus.rs_ID = 5;
        @(negedge CLK);
        chk("lu_pc_en", bus.pc_en, 0);
        chk("lu_ifid_en", bus.ifid_en, 0);
        chk("lu_ifid_flush", bus.ifid_flush, 0);
        chk("lu_idex_flush", bus.idex_flush, 1);
        chk("lu_exmem_en", bus.exmem_en, 1);
        chk("lu_cnt0", bus.stall_count, 0);
        nxt(); idle();
        @(negedge CLK);
        chk("lu_cnt1", bus.stall_count, 1);
        // load to r0 is not a hazard
        nxt(); bus.memread_EX = 1; bus.rd_EX = 0; bus.rs_ID = 0;
        @(negedge CLK);
        chk("lu_r0_pc_en", bus.pc_en, 1);

        // taken branch with ihit
        nxt(); idle(); bus.branch_taken_EX = 1; bus.branch_target_EX = 32'h40;
        @(negedge CLK);
        chk("br_redirect", bus.pc_redirect, 1);
        chk("br_addr", bus.redirect_addr, 32'h40);
        chk("br_flush", {bus.ifid_flush, bus.idex_flush}, 2'b11);
        chk("br_pc_en", bus.pc_en, 1);
        nxt(); idle();
        @(negedge CLK);
        chk("br_back_run", bus.pc_redirect, 0);

        // taken branch without ihit, then REDIRECT held
        nxt(); bus.branch_taken_EX = 1; bus.branch_target_EX = 32'h80; bus.ihit = 0;
        @(negedge CLK);
        chk("brn_pc_en", bus.pc_en, 0);
        chk("brn_addr", bus.redirect_addr, 32'h80);
        for (int i = 0; i < 2; i++) begin
            nxt(); bus.branch_taken_EX = 0; bus.branch_target_EX = 32'h1234; bus.ihit = 0;
            @(negedge CLK);
            chk("redir_addr", bus.redirect_addr, 32'h80);
            chk("redir_flag", bus.pc_redirect, 1);
            chk("redir_pc_en", bus.pc_en, 0);
        end
        // dwait in REDIRECT freezes everything
        for (int i = 0; i < 2; i++) begin
            nxt(); bus.dmemREN_MEM = 1; bus.dhit = 0;
            @(negedge CLK);
            chk("dw_en", {bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en}, 4'h0);
            chk("dw_flush", {bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.memwb_flush}, 4'h0);
            chk("dw_addr", bus.redirect_addr, 32'h80);
        end
        nxt(); bus.dmemREN_MEM = 0; bus.ihit = 1;
        @(negedge CLK);
        chk("redir_go_pc_en", bus.pc_en, 1);
        chk("redir_go_addr", bus.redirect_addr, 32'h80);
        nxt(); idle();
        @(negedge CLK);
        chk("redir_done", bus.pc_redirect, 0);
        chk("cnt6", bus.stall_count, 6);

        // jump, then instruction wait
        nxt(); bus.jump_ID = 1;
        @(negedge CLK);
        chk("jmp_ifid_flush", bus.ifid_flush, 1);
        chk("jmp_pc_en", bus.pc_en, 1);
        nxt(); bus.jump_ID = 0; bus.ihit = 0;
        @(negedge CLK);
        chk("iw_ifid_flush", bus.ifid_flush, 1);
        chk("iw_idex_en", bus.idex_en, 1);
        chk("iw_pc_en", bus.pc_en, 0);

        // halt: first blocked by dwait, then taken
        nxt(); idle(); bus.halt_MEM = 1; bus.dmemREN_MEM = 1; bus.dhit = 0;
        @(negedge CLK);
        chk("hdw_memwb_en", bus.memwb_en, 0);
        nxt(); bus.dhit = 1;
        @(negedge CLK);
        chk("h_memwb_en", bus.memwb_en, 1);
        chk("h_flush", {bus.ifid_flush, bus.idex_flush, bus.exmem_flush}, 3'b111);
        chk("h_pc_en", bus.pc_en, 0);
        chk("h_halt_pre", bus.halt, 0);
        nxt(); idle();
        @(negedge CLK);
        chk("h_halt", bus.halt, 1);
        chk("h_drain_en", bus.memwb_en, 0);
        for (int i = 0; i < 6; i++) begin
            nxt(); bus.ihit = i[0];
            @(negedge CLK);
            chk("halted_halt", bus.halt, 1);
            chk("halted_pc_en", bus.pc_en, 0);
        end
        chk("halted_cnt", bus.stall_count, 9);
        nxt(); idle(); RST = 1;
        nxt(); RST = 0;
        @(negedge CLK);
        chk("hrst_halt", bus.halt, 0);
        chk("hrst_cnt", bus.stall_count, 0);
        chk("hrst_pc_en", bus.pc_en, 1);

        // reset while in REDIRECT drops the redirect
        nxt(); bus.branch_taken_EX = 1; bus.branch_target_EX = 32'h99; bus.ihit = 0;
        nxt(); bus.branch_taken_EX = 0; RST = 1;
        nxt(); RST = 0;
        @(negedge CLK);
        chk("rrst_redirect", bus.pc_redirect, 0);
        chk("rrst_cnt", bus.stall_count, 0);

        // stall counter saturates
        for (int i = 0; i < 20; i++) nxt();
        @(negedge CLK);
        chk("cnt_sat", bus.stall_count, CNT_MAX);
        nxt(); idle();
        @(negedge CLK);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
